dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a cpu and a debug/loader requester onto one single-port data memory.
// Latency: gnt in cycle N (same cycle as req), mem access N+1, ack + read data N+2; one access per 2 cycles.
// Backpressure: requesters hold req until gnt; a req dropped before gnt is discarded, no memory access.
// Ports: clock, reset (synchronous, active-high);
//        cpu_req/cpu_wren/cpu_addr/cpu_wdata in, cpu_gnt/cpu_ack/cpu_rdata out;
//        dbg_req/dbg_wren/dbg_lock/dbg_addr/dbg_wdata in, dbg_gnt/dbg_ack/dbg_rdata out;
//        mem_en/mem_wren/mem_addr/mem_wdata out, mem_rdata in (valid one cycle after a read mem_en).
// Build option: DMEM_ARB_RR_EN selects round-robin between requesters instead of fixed cpu priority.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_wren,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W    = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_TOP = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              arb_ok;
  logic              gnt_cpu, gnt_dbg, gnt_any;
  logic              force_cpu, lock_hold, cpu_first;
  logic              resp_ok, rd_done;
  logic [CNT_W-1:0]  lock_cnt;
  logic              own_dbg;
  logic              cmd_wren;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

`ifdef DMEM_ARB_RR_EN
  // Remembers who won the last grant; reset value makes cpu win the first tie.
  logic last_dbg;
  always_ff @(posedge clock) begin
    if (reset)        last_dbg <= 1'b1;
    else if (gnt_any) last_dbg <= gnt_dbg;
  end
  assign cpu_first = last_dbg;
`else
  assign cpu_first = 1'b1;
`endif

  // Lock bookkeeping: once a locked dbg grant has been given (count non-zero), dbg keeps
  // winning while it requests with lock held, until LOCK_MAX grants force a cpu slot.
  assign force_cpu = cpu_req && (lock_cnt == LOCK_TOP);
  assign lock_hold = dbg_req && dbg_lock && (lock_cnt != '0);

  always_comb begin
    state_nxt = state;
    gnt_cpu   = 1'b0;
    gnt_dbg   = 1'b0;
    // Grants are suppressed while reset is high so a held request is taken the cycle after.
    arb_ok    = !reset && (state != ACCESS);
    if (arb_ok) begin
      if (force_cpu)                          gnt_cpu = 1'b1;
      else if (lock_hold)                     gnt_dbg = 1'b1;
      else if (cpu_req && (!dbg_req || cpu_first)) gnt_cpu = 1'b1;
      else if (dbg_req)                       gnt_dbg = 1'b1;
    end
    case (state)
      IDLE:    if (gnt_cpu || gnt_dbg) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = (gnt_cpu || gnt_dbg) ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_any = gnt_cpu || gnt_dbg;
  assign resp_ok = !reset && (state == RESP);
  assign rd_done = resp_ok && !cmd_wren;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      own_dbg     <= 1'b0;
      cmd_wren    <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        own_dbg   <= gnt_dbg;
        cmd_wren  <= gnt_dbg ? dbg_wren  : cpu_wren;
        cmd_addr  <= gnt_dbg ? dbg_addr  : cpu_addr;
        cmd_wdata <= gnt_dbg ? dbg_wdata : cpu_wdata;
      end
      if (arb_ok) begin
        if (gnt_cpu || !dbg_lock)                   lock_cnt <= '0;
        else if (gnt_dbg && (lock_cnt != LOCK_TOP)) lock_cnt <= lock_cnt + 1'b1;
      end
      if (rd_done && !own_dbg) cpu_rdata_q <= mem_rdata;
      if (rd_done &&  own_dbg) dbg_rdata_q <= mem_rdata;
    end
  end

  assign cpu_gnt   = gnt_cpu;
  assign dbg_gnt   = gnt_dbg;
  assign cpu_ack   = resp_ok && !own_dbg;
  assign dbg_ack   = resp_ok &&  own_dbg;
  // Read data is forwarded in the ack cycle, then held in the register until the next read.
  assign cpu_rdata = (rd_done && !own_dbg) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = (rd_done &&  own_dbg) ? mem_rdata : dbg_rdata_q;
  assign mem_en    = (state == ACCESS);
  assign mem_wren  = mem_en && cmd_wren;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural single-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int LM = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock, reset;
  logic          cpu_req, cpu_wren, cpu_gnt, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_wren, dbg_lock, dbg_gnt, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_wren(dbg_wren), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Power-up contents of the memory; address 5 holds 0x1234.
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 16'h1234;
    return DW'((a * 37) ^ 32'h5A5A);
  endfunction

  // Synchronous single-port RAM: read data appears the cycle after mem_en.
  logic [DW-1:0] ram     [0:4095];
  bit            wr_seen [0:4095];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wren) begin
        ram[mem_addr]     <= mem_wdata;
        wr_seen[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wr_seen[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
      end
    end
  end

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    nc();
    reset   = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 12'hFFF;
    return AW'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic          cr, dr, dl;
    logic          ecg, edg, een;
    logic [AW-1:0] eaddr;
  } vec_t;

  typedef struct {
    bit            v;
    int            who;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } acc_t;

  logic [DW-1:0] shadow [0:4095];

  initial begin
    vec_t          vt [6];
    acc_t          a1, a2;
    int            free_at, lockc, last, win;
    bit            cp, dp;
    logic [DW-1:0] m_cpu_rd, m_dbg_rd;

    reset = 1'b1;
    cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_wren = 1'b0; dbg_lock = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0A0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0B0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0A0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0A0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0B0};

    // Reset values
    do_reset();
    #2;
    chk_b("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk_b("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk_b("rst_cpu_ack", cpu_ack, 1'b0);
    chk_b("rst_dbg_ack", dbg_ack, 1'b0);
    chk_b("rst_mem_en", mem_en, 1'b0);
    chk_b("rst_mem_wren", mem_wren, 1'b0);
    chk_w("rst_mem_addr", 16'(mem_addr), 16'h0);
    chk_w("rst_mem_wdata", mem_wdata, 16'h0);
    chk_w("rst_cpu_rdata", cpu_rdata, 16'h0);
    chk_w("rst_dbg_rdata", dbg_rdata, 16'h0);

    // Single arbitration out of IDLE for each request pattern
    for (int i = 0; i < 6; i++) begin
      do_reset();
      cpu_req = vt[i].cr; cpu_wren = 1'b0; cpu_addr = 12'h0A0;
      dbg_req = vt[i].dr; dbg_wren = 1'b0; dbg_addr = 12'h0B0; dbg_lock = vt[i].dl;
      #2;
      chk_b($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vt[i].ecg);
      chk_b($sformatf("vec%0d_dbg_gnt", i), dbg_gnt, vt[i].edg);
      nc(); cpu_req = 1'b0; dbg_req = 1'b0; #2;
      chk_b($sformatf("vec%0d_mem_en", i), mem_en, vt[i].een);
      chk_w($sformatf("vec%0d_mem_addr", i), 16'(mem_addr), 16'(vt[i].eaddr));
      nc(); #2;
      chk_b($sformatf("vec%0d_cpu_ack", i), cpu_ack, vt[i].ecg);
      chk_b($sformatf("vec%0d_dbg_ack", i), dbg_ack, vt[i].edg);
    end
    dbg_lock = 1'b0;

    // cpu read of address 5: gnt N, access N+1, ack with data N+2, data held afterwards
    do_reset();
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h005; #2;
    chk_b("rd5_gnt", cpu_gnt, 1'b1);
    nc(); cpu_req = 1'b0; #2;
    chk_b("rd5_mem_en", mem_en, 1'b1);
    chk_w("rd5_mem_addr", 16'(mem_addr), 16'h005);
    chk_b("rd5_mem_wren", mem_wren, 1'b0);
    nc(); #2;
    chk_b("rd5_ack", cpu_ack, 1'b1);
    chk_b("rd5_dbg_ack", dbg_ack, 1'b0);
    chk_w("rd5_rdata", cpu_rdata, 16'h1234);
    nc(); #2;
    chk_b("rd5_ack_pulse", cpu_ack, 1'b0);
    chk_w("rd5_rdata_hold", cpu_rdata, 16'h1234);

    // Reset during the ACCESS cycle aborts the read
    cpu_req = 1'b1; cpu_addr = 12'h005; #2;
    chk_b("abort_gnt", cpu_gnt, 1'b1);
    nc(); cpu_req = 1'b0; reset = 1'b1; #2;
    chk_b("abort_mem_en", mem_en, 1'b1);
    nc(); reset = 1'b0; #2;
    chk_b("abort_no_ack", cpu_ack, 1'b0);
    chk_b("abort_mem_en0", mem_en, 1'b0);
    chk_b("abort_mem_wren", mem_wren, 1'b0);
    chk_w("abort_mem_addr", 16'(mem_addr), 16'h0);
    chk_w("abort_mem_wdata", mem_wdata, 16'h0);
    chk_w("abort_cpu_rdata", cpu_rdata, 16'h0);
    chk_w("abort_dbg_rdata", dbg_rdata, 16'h0);
    chk_b("abort_cpu_gnt", cpu_gnt, 1'b0);

    // Request held through reset is granted in the first cycle after reset
    reset = 1'b1; cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h033; #2;
    chk_b("held_gnt_in_reset", cpu_gnt, 1'b0);
    nc(); reset = 1'b0; #2;
    chk_b("held_gnt_after", cpu_gnt, 1'b1);
    nc(); cpu_req = 1'b0; #2;
    chk_w("held_mem_addr", 16'(mem_addr), 16'h033);
    nc(); #2;
    chk_b("held_ack", cpu_ack, 1'b1);
    chk_w("held_rdata", cpu_rdata, init_val(16'h033));

    // Simultaneous requests: cpu first, dbg granted in cpu's RESP cycle
    do_reset();
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h040;
    dbg_req = 1'b1; dbg_wren = 1'b0; dbg_addr = 12'h041; dbg_lock = 1'b0; #2;
    chk_b("both_cpu_gnt", cpu_gnt, 1'b1);
    chk_b("both_dbg_wait", dbg_gnt, 1'b0);
    nc(); cpu_req = 1'b0; #2;
    chk_b("both_access_no_gnt", dbg_gnt, 1'b0);
    chk_w("both_addr_cpu", 16'(mem_addr), 16'h040);
    nc(); #2;
    chk_b("both_cpu_ack", cpu_ack, 1'b1);
    chk_b("both_dbg_gnt_resp", dbg_gnt, 1'b1);
    chk_b("both_cpu_gnt_resp", cpu_gnt, 1'b0);
    nc(); dbg_req = 1'b0; #2;
    chk_w("both_addr_dbg", 16'(mem_addr), 16'h041);
    nc(); #2;
    chk_b("both_dbg_ack", dbg_ack, 1'b1);
    chk_b("both_cpu_ack0", cpu_ack, 1'b0);

    // Both held for four back-to-back grants
    do_reset();
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk_b($sformatf("b2b%0d_cpu_gnt", k), cpu_gnt, RR ? (k % 2 == 0) : 1'b1);
      chk_b($sformatf("b2b%0d_dbg_gnt", k), dbg_gnt, RR ? (k % 2 == 1) : 1'b0);
      nc(); nc();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    nc(); nc();

    // Locked dbg writes starve cpu for LOCK_MAX grants, then cpu is forced in
    do_reset();
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_wren = 1'b1; dbg_addr = 12'h010; dbg_wdata = 16'h00FF; #2;
    chk_b("lock_dbg_gnt0", dbg_gnt, 1'b1);
    nc(); cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h020; #2;
    chk_b("lock_mem_wren", mem_wren, 1'b1);
    chk_w("lock_mem_addr", 16'(mem_addr), 16'h010);
    chk_w("lock_mem_wdata", mem_wdata, 16'h00FF);
    for (int g = 1; g < LM; g++) begin
      nc(); #2;
      chk_b($sformatf("lock_dbg_gnt%0d", g), dbg_gnt, 1'b1);
      chk_b($sformatf("lock_cpu_held%0d", g), cpu_gnt, 1'b0);
      nc();
    end
    nc(); #2;
    chk_b("lock_forced_cpu", cpu_gnt, 1'b1);
    chk_b("lock_forced_dbg0", dbg_gnt, 1'b0);
    nc(); cpu_req = 1'b0;
    nc(); #2;
    chk_b("lock_relock_dbg", dbg_gnt, 1'b1);
    nc(); cpu_req = 1'b1;
    nc(); #2;
    chk_b("lock_cleared_dbg", dbg_gnt, 1'b1);
    chk_b("lock_cleared_cpu", cpu_gnt, 1'b0);
    nc(); cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; dbg_wren = 1'b0;
    nc(); nc();

    // cpu write then read of 0xFFF; dbg read data untouched
    do_reset();
    dbg_req = 1'b1; dbg_wren = 1'b0; dbg_addr = 12'h007; #2;
    chk_b("wr_dbg_gnt", dbg_gnt, 1'b1);
    nc(); dbg_req = 1'b0;
    nc(); #2;
    chk_w("wr_dbg_rdata", dbg_rdata, init_val(7));
    nc();
    cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'hFFF; cpu_wdata = 16'hBEEF; #2;
    chk_b("wr_cpu_gnt", cpu_gnt, 1'b1);
    nc(); cpu_req = 1'b0; #2;
    chk_b("wr_mem_wren", mem_wren, 1'b1);
    chk_w("wr_mem_addr", 16'(mem_addr), 16'hFFF);
    chk_w("wr_mem_wdata", mem_wdata, 16'hBEEF);
    nc(); cpu_req = 1'b1; cpu_wren = 1'b0; #2;
    chk_b("wr_cpu_ack", cpu_ack, 1'b1);
    chk_w("wr_rdata_unchanged", cpu_rdata, 16'h0);
    chk_b("rd_cpu_gnt", cpu_gnt, 1'b1);
    nc(); cpu_req = 1'b0; #2;
    chk_b("rd_mem_wren", mem_wren, 1'b0);
    nc(); #2;
    chk_b("rd_cpu_ack", cpu_ack, 1'b1);
    chk_w("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
    chk_w("rd_dbg_rdata_kept", dbg_rdata, init_val(7));
    nc(); nc();

    // Randomized traffic against a transaction-level reference model
    do_reset();
    for (int a = 0; a < 4096; a++) shadow[a] = wr_seen[a] ? ram[a] : init_val(a);
    free_at = 0; lockc = 0; last = 2; cp = 1'b0; dp = 1'b0;
    m_cpu_rd = '0; m_dbg_rd = '0;
    a1 = '{default: 0}; a2 = '{default: 0};
    for (int t = 0; t < 3000; t++) begin
      if (!cp) begin
        if ($urandom_range(0, 2) == 0) begin
          cp = 1'b1; cpu_wren = 1'($urandom_range(0, 1));
          cpu_addr = pick_addr(); cpu_wdata = DW'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) cp = 1'b0;
      if (!dp) begin
        if ($urandom_range(0, 2) == 0) begin
          dp = 1'b1; dbg_wren = 1'($urandom_range(0, 1));
          dbg_addr = pick_addr(); dbg_wdata = DW'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) dp = 1'b0;
      if ($urandom_range(0, 7) == 0) dbg_lock = ~dbg_lock;
      cpu_req = cp; dbg_req = dp;
      #2;
      // Expected winner from the arbitration rules; 1 = cpu, 2 = dbg
      win = 0;
      if (t >= free_at) begin
        if (cp && lockc >= LM)                win = 1;
        else if (dp && dbg_lock && lockc > 0) win = 2;
        else if (cp && dp)                    win = (RR && last == 1) ? 2 : 1;
        else if (cp)                          win = 1;
        else if (dp)                          win = 2;
      end
      chk_b("r_cpu_gnt", cpu_gnt, win == 1);
      chk_b("r_dbg_gnt", dbg_gnt, win == 2);
      chk_b("r_mem_en", mem_en, a1.v);
      if (a1.v) begin
        chk_b("r_mem_wren", mem_wren, a1.wren);
        chk_w("r_mem_addr", 16'(mem_addr), 16'(a1.addr));
        if (a1.wren) chk_w("r_mem_wdata", mem_wdata, a1.wdata);
      end
      chk_b("r_cpu_ack", cpu_ack, a2.v && a2.who == 1);
      chk_b("r_dbg_ack", dbg_ack, a2.v && a2.who == 2);
      if (a2.v && !a2.wren) begin
        if (a2.who == 1) m_cpu_rd = a2.rdata;
        else             m_dbg_rd = a2.rdata;
      end
      chk_w("r_cpu_rdata", cpu_rdata, m_cpu_rd);
      chk_w("r_dbg_rdata", dbg_rdata, m_dbg_rd);
      if (t >= free_at) begin
        if (win == 1 || !dbg_lock)      lockc = 0;
        else if (win == 2 && lockc < LM) lockc++;
      end
      a2 = a1;
      a1 = '{default: 0};
      if (win != 0) begin
        a1.v     = 1'b1;
        a1.who   = win;
        a1.wren  = (win == 1) ? cpu_wren  : dbg_wren;
        a1.addr  = (win == 1) ? cpu_addr  : dbg_addr;
        a1.wdata = (win == 1) ? cpu_wdata : dbg_wdata;
        if (a1.wren) shadow[a1.addr] = a1.wdata;
        else         a1.rdata = shadow[a1.addr];
        free_at = t + 2;
        last    = win;
        if (win == 1) cp = 1'b0;
        else          dp = 1'b0;
      end
      nc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
